dtw_trace_collector: RTL and testbench

Traceback collector for the DTW array. It sits at the array boundary and receives the backtrack stream that the per-cell score units produce. On a start request it drives the one-cycle enable into the terminal cell (T_LAST,R_LAST). It then captures the {tindex,rindex} emitted by the active cell each cycle and writes the path, terminal-first, into the path SRAM. It stops cleanly at the origin (0,0) or on a detected fault.

---
 rtl/dtw_pkg.sv | 34 +++
 rtl/dtw_step_checker.sv | 39 +++
 rtl/dtw_trace_collector.sv | 161 ++++++++++++++++
 tb/tb_dtw_trace_collector.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtw_pkg.sv
// dtw_pkg: shared definitions for the DTW array traceback path.
//   - state_e           : trace collector FSM states
//   - ERR_*             : collector error codes reported on o_err
//   - IDX_W             : width of one index coordinate (tindex or rindex)
//   - PATH*             : per-cell backtrack direction codes, shared with the score units
//   - T_LAST/R_LAST     : coordinates of the terminal cell (31 is reserved as invalid)
//   - MAX_STEPS         : longest legal path, T_LAST + R_LAST + 1 entries
package dtw_pkg;

    localparam int unsigned IDX_W = 5;

    // Backtrack direction stored by each cell; PATH_RST marks a cell that never scored.
    localparam logic [1:0] PATH_RST = 2'b00;
    localparam logic [1:0] PATH0    = 2'b01;  // diagonal (t-1, r-1)
    localparam logic [1:0] PATH1    = 2'b10;  // (t-1, r)
    localparam logic [1:0] PATH2    = 2'b11;  // (t, r-1)

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_BROKEN   = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;
    localparam logic [1:0] ERR_STEP     = 2'b11;

    localparam logic [IDX_W-1:0] T_LAST    = 5'd30;
    localparam logic [IDX_W-1:0] R_LAST    = 5'd30;
    localparam int unsigned      MAX_STEPS = 61;

    typedef enum logic [1:0] {
        StIdle,
        StKick,
        StCollect,
        StFin
    } state_e;

endpackage

// File: rtl/dtw_step_checker.sv
// dtw_step_checker: combinational legality check of one traceback step.
// Ports:
//   prev_idx  in  10  previously accepted index {tindex, rindex}
//   cur_idx   in  10  index currently on the bus
//   first     in  1   cur_idx is the first index of the path
//   ok        out 1   first: cur_idx is the terminal cell;
//                     otherwise: cur_idx = prev_idx - (1,1), (1,0) or (0,1) with no underflow
module dtw_step_checker
    import dtw_pkg::*;
(
    input  logic [2*IDX_W-1:0] prev_idx,
    input  logic [2*IDX_W-1:0] cur_idx,
    input  logic               first,
    output logic               ok
);

    logic [IDX_W:0] prev_t, prev_r, cur_t, cur_r;
    logic           t_dec, r_dec, t_same, r_same;

    // One extra bit so cur+1 cannot wrap; a decrement from 0 can then never match.
    assign prev_t = {1'b0, prev_idx[2*IDX_W-1:IDX_W]};
    assign prev_r = {1'b0, prev_idx[IDX_W-1:0]};
    assign cur_t  = {1'b0, cur_idx[2*IDX_W-1:IDX_W]};
    assign cur_r  = {1'b0, cur_idx[IDX_W-1:0]};

    assign t_dec  = prev_t == cur_t + 1'b1;
    assign r_dec  = prev_r == cur_r + 1'b1;
    assign t_same = prev_t == cur_t;
    assign r_same = prev_r == cur_r;

    always_comb begin
        if (first) begin
            ok = cur_idx == {T_LAST, R_LAST};
        end else begin
            ok = (t_dec && (r_dec || r_same)) || (t_same && r_dec);
        end
    end

endmodule

// File: rtl/dtw_trace_collector.sv
// dtw_trace_collector: collects the DTW backtrack path from the array and writes it,
// terminal cell first, into the path SRAM.
// Build option: define DTW_TRACE_CHECK_EN to check each step for legality (error code STEP).
// Ports:
//   clk            in  1   clock
//   nrst           in  1   asynchronous active-low reset
//   i_start        in  1   traceback request, honoured only when idle
//   i_trace_vld    in  1   some cell is driving the index bus
//   i_trace_index  in  10  {tindex, rindex} of the active cell
//   o_kick         out 1   enable into the terminal cell
//   o_busy         out 1   traceback in progress (kick through done)
//   o_we           out 1   path SRAM write strobe
//   o_waddr        out 6   path SRAM address, 0 = terminal cell
//   o_wdata        out 10  path SRAM data {tindex, rindex}
//   o_done         out 1   one-cycle completion pulse
//   o_len          out 6   entries written in the last traceback
//   o_err          out 2   00 none, 01 broken, 10 overflow, 11 step; sticky until next start
module dtw_trace_collector
    import dtw_pkg::*;
(
    input  logic               clk,
    input  logic               nrst,
    input  logic               i_start,
    input  logic               i_trace_vld,
    input  logic [2*IDX_W-1:0] i_trace_index,
    output logic               o_kick,
    output logic               o_busy,
    output logic               o_we,
    output logic [5:0]         o_waddr,
    output logic [2*IDX_W-1:0] o_wdata,
    output logic               o_done,
    output logic [5:0]         o_len,
    output logic [1:0]         o_err
);

    state_e state_q, state_d;

    logic [5:0]         addr_q;
    logic [1:0]         err_q;
    logic               we_q;
    logic [5:0]         waddr_q;
    logic [2*IDX_W-1:0] wdata_q;

    logic       capture;
    logic       step_ok;
    logic       wr_en;
    logic       finish;
    logic [1:0] err_d;
    logic       at_origin;
    logic       at_limit;

    // The terminal cell answers the kick combinationally, so KICK captures too.
    assign capture   = (state_q == StKick) || (state_q == StCollect);
    assign at_origin = i_trace_index == '0;
    assign at_limit  = ({1'b0, addr_q} + 7'd1) == 7'(MAX_STEPS);

`ifdef DTW_TRACE_CHECK_EN
    logic [2*IDX_W-1:0] prev_q;

    dtw_step_checker u_step_checker (
        .prev_idx (prev_q),
        .cur_idx  (i_trace_index),
        .first    (state_q == StKick),
        .ok       (step_ok)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prev_q <= '0;
        end else if (wr_en) begin
            prev_q <= i_trace_index;
        end
    end
`else
    assign step_ok = 1'b1;
`endif

    // Capture decision for the current bus value.
    always_comb begin
        wr_en  = 1'b0;
        finish = 1'b0;
        err_d  = ERR_NONE;
        if (capture) begin
            if (!i_trace_vld) begin
                err_d  = ERR_BROKEN;
                finish = 1'b1;
            end else if (!step_ok) begin
                err_d  = ERR_STEP;
                finish = 1'b1;
            end else begin
                wr_en = 1'b1;
                // Zero is the origin only because vld is high here.
                if (at_origin) begin
                    finish = 1'b1;
                end else if (at_limit) begin
                    err_d  = ERR_OVERFLOW;
                    finish = 1'b1;
                end
            end
        end
    end

    // FSM: state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:            if (i_start) state_d = StKick;
            StKick, StCollect: state_d = finish ? StFin : StCollect;
            StFin:             state_d = StIdle;
            default:           state_d = StIdle;
        endcase
    end

    // FSM: outputs decoded from the state register.
    always_comb begin
        o_kick = state_q == StKick;
        o_busy = state_q != StIdle;
        o_done = state_q == StFin;
    end

    // Registered SRAM write port, address counter and status.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            addr_q  <= '0;
            err_q   <= ERR_NONE;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= wr_en;
            if (state_q == StIdle && i_start) begin
                addr_q <= '0;
                err_q  <= ERR_NONE;
            end else if (wr_en) begin
                waddr_q <= addr_q;
                wdata_q <= i_trace_index;
                addr_q  <= addr_q + 6'd1;
            end
            if (capture && err_d != ERR_NONE) begin
                err_q <= err_d;
            end
        end
    end

    assign o_we    = we_q;
    assign o_waddr = waddr_q;
    assign o_wdata = wdata_q;
    // The address counter doubles as the write count.
    assign o_len   = addr_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_dtw_trace_collector.sv
// Testbench for dtw_trace_collector: the bench plays the DTW array, replaying a path
// list cycle by cycle after each kick; a reference model derives the expected writes
// and completion status, and a monitor checks them as the DUT presents them.
module tb_dtw_trace_collector;

`ifdef DTW_TRACE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int LIMIT = 61;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       i_start = 1'b0;
    logic       i_trace_vld = 1'b0;
    logic [9:0] i_trace_index = '0;
    logic       o_kick, o_busy, o_we, o_done;
    logic [5:0] o_waddr, o_len;
    logic [9:0] o_wdata;
    logic [1:0] o_err;

    dtw_trace_collector dut (
        .clk           (clk),
        .nrst          (nrst),
        .i_start       (i_start),
        .i_trace_vld   (i_trace_vld),
        .i_trace_index (i_trace_index),
        .o_kick        (o_kick),
        .o_busy        (o_busy),
        .o_we          (o_we),
        .o_waddr       (o_waddr),
        .o_wdata       (o_wdata),
        .o_done        (o_done),
        .o_len         (o_len),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int len; int err; int cyc; } done_t;

    wr_t        exp_wr[$];
    done_t      exp_done[$];
    logic [9:0] path_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    wr_t        mon_w;
    done_t      mon_d;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare every write and completion against the scoreboard.
    always @(negedge clk) begin
        if (nrst) begin
            if (o_we) begin
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: addr %0d data %0h", o_waddr, o_wdata);
                end else begin
                    mon_w = exp_wr.pop_front();
                    check("waddr", int'(o_waddr), mon_w.addr);
                    check("wdata", int'(o_wdata), mon_w.data);
                end
            end
            if (o_done) begin
                if (exp_done.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: len %0d err %0d", o_len, o_err);
                end else begin
                    mon_d = exp_done.pop_front();
                    check("len", int'(o_len), mon_d.len);
                    check("err", int'(o_err), mon_d.err);
                    check("done_cycle", cyc, mon_d.cyc);
                end
            end
        end
    end

    function automatic bit legal_step(input logic [9:0] prev, input logic [9:0] cur);
        int dt, dr;
        dt = int'(prev[9:5]) - int'(cur[9:5]);
        dr = int'(prev[4:0]) - int'(cur[4:0]);
        return (dt == 1 && dr == 1) || (dt == 1 && dr == 0) || (dt == 0 && dr == 1);
    endfunction

    // Reference model: walk the path the array will present, the first `avail`
    // entries with vld high, and queue up the writes it must produce.
    task automatic expect_trace(input int avail, output int captures, output int len,
                                output int err);
        int j;
        len = 0;
        err = 0;
        j = 0;
        forever begin
            if (j >= avail || j >= path_q.size()) begin
                err = 1;
                break;
            end
            if (CHK && ((j == 0 && path_q[0] != 10'h3DE) ||
                        (j > 0 && !legal_step(path_q[j-1], path_q[j])))) begin
                err = 3;
                break;
            end
            exp_wr.push_back('{addr: j, data: int'(path_q[j])});
            len++;
            if (path_q[j] == 10'd0) break;
            if (len == LIMIT) begin
                err = 2;
                break;
            end
            j++;
        end
        captures = j + 1;
    endtask

    task automatic drive_bus(input int j, input int avail);
        if (j < avail && j < path_q.size()) begin
            i_trace_vld   = 1'b1;
            i_trace_index = path_q[j];
        end else begin
            i_trace_vld   = 1'b0;
            i_trace_index = '0;
        end
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!o_busy) begin
                idle = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (!idle) begin
            n_errors++;
            $display("FAIL idle_timeout: o_busy still 1, expected 0");
        end
    endtask

    task automatic run_trace(input int avail);
        int    captures, len, err;
        done_t d;
        @(negedge clk);
        expect_trace(avail, captures, len, err);
        d.len = len;
        d.err = err;
        d.cyc = cyc + 1 + captures;
        exp_done.push_back(d);
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        check("kick", int'(o_kick), 1);
        for (int j = 0; j < captures; j++) begin
            drive_bus(j, avail);
            @(posedge clk);
            #1;
        end
        drive_bus(-1, 0);
        wait_idle();
    endtask

    function automatic logic [9:0] idx(input int t, input int r);
        return {5'(t), 5'(r)};
    endfunction

    task automatic build_diag();
        path_q.delete();
        for (int i = 30; i >= 0; i--) path_q.push_back(idx(i, i));
    endtask

    task automatic build_random();
        int t, r, s;
        t = 30;
        r = 30;
        path_q.delete();
        path_q.push_back(idx(t, r));
        while (t != 0 || r != 0) begin
            s = $urandom_range(0, 2);
            if (t == 0) s = 2;
            if (r == 0) s = 1;
            if (s != 2) t--;
            if (s != 1) r--;
            path_q.push_back(idx(t, r));
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_kick"}, int'(o_kick), 0);
        check({tag, "_busy"}, int'(o_busy), 0);
        check({tag, "_we"}, int'(o_we), 0);
        check({tag, "_waddr"}, int'(o_waddr), 0);
        check({tag, "_wdata"}, int'(o_wdata), 0);
        check({tag, "_done"}, int'(o_done), 0);
        check({tag, "_len"}, int'(o_len), 0);
        check({tag, "_err"}, int'(o_err), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(posedge clk);

        // Pure diagonal: 31 writes, first 10'h3DE.
        build_diag();
        run_trace(1000);

        // Mixed path with one (1,0) step: 32 writes.
        path_q.delete();
        path_q.push_back(idx(30, 30));
        path_q.push_back(idx(29, 30));
        for (int i = 29; i >= 0; i--) path_q.push_back(idx(i, i));
        run_trace(1000);

        // vld drops after 5 entries.
        build_diag();
        run_trace(5);

        // Nothing on the bus at the kick.
        run_trace(0);

        // Never reaches the origin: overflow after 61 writes.
        path_q.delete();
        for (int i = 0; i < 70; i++) path_q.push_back(idx(30 - (i % 10), 30));
        run_trace(1000);

        // Illegal jump (20,20) -> (18,20).
        path_q.delete();
        for (int i = 30; i >= 20; i--) path_q.push_back(idx(i, i));
        path_q.push_back(idx(18, 20));
        for (int i = 17; i >= 0; i--) path_q.push_back(idx(i, i + 2));
        path_q.push_back(idx(0, 1));
        path_q.push_back(idx(0, 0));
        run_trace(1000);

        // Random legal paths, some cut short.
        for (int n = 0; n < 20; n++) begin
            build_random();
            run_trace(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 60)) : 1000);
        end

        // Second start mid-collect is ignored; reset at entry 10 aborts everything.
        build_diag();
        @(negedge clk);
        i_start = 1'b1;
        for (int j = 0; j < 10; j++) exp_wr.push_back('{addr: j, data: int'(path_q[j])});
        @(posedge clk);
        #1;
        i_start = 1'b0;
        for (int j = 0; j < 10; j++) begin
            if (j == 4) begin
                check("restart_kick", int'(o_kick), 0);
                check("restart_busy", int'(o_busy), 1);
            end
            drive_bus(j, 1000);
            i_start = (j == 3);
            @(posedge clk);
            #1;
        end
        i_start = 1'b0;
        drive_bus(10, 1000);
        @(negedge clk);
        #1;
        nrst = 1'b0;
        #1;
        check_reset_values("midreset");
        drive_bus(-1, 0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(posedge clk);

        // Full traceback after the aborted one.
        build_diag();
        run_trace(1000);

        repeat (4) @(posedge clk);
        #1;
        check("pending_writes", exp_wr.size(), 0);
        check("pending_done", exp_done.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
